wb_board_arbiter: RTL and testbench
===================================

Name: wb_board_arbiter

Overview:
Round-robin arbiter that shares the single board-memory Wishbone slave (8-bit address over the 16x16 cell array, 8-bit data) among NUM_MASTERS requesters: game logic, display reader and mine generator. It grants the bus per cycle-frame (m_cyc), muxes the granted master onto the slave, and routes ack, stall and read data back. It also tracks outstanding pipelined transfers and releases a bus held by an unresponsive slave after a timeout.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8)
ADDR_W, 8, address width
DATA_W, 8, data width
MAX_OUTST, 15, maximum accepted-but-unacked transfers per grant
TIMEOUT, 255, cycles without ack while transfers are outstanding before forced release

Ports:
CLK_I  in  1  system clock
RST_I  in  1  synchronous reset, active-low
m_cyc_i  in  NUM_MASTERS  per-master cycle request
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_adr_i  in  NUM_MASTERS*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
m_dat_i  in  NUM_MASTERS*DATA_W  packed write data
m_dat_o  out  DATA_W  read data broadcast to all masters (s_dat_i)
m_ack_o  out  NUM_MASTERS  ack, granted master only
m_stall_o  out  NUM_MASTERS  stall per master
s_cyc_o, s_stb_o, s_we_o  out  1  to slave
s_adr_o  out  ADDR_W  to slave
s_dat_o  out  DATA_W  to slave
s_dat_i  in  DATA_W  slave read data
s_ack_i  in  1  slave ack
s_stall_i  in  1  slave stall
gnt_o  out  NUM_MASTERS  one-hot registered grant
busy_o  out  1  state == BUSY
timeout_o  out  1  one-cycle pulse on forced release
timeout_id_o  out  $clog2(NUM_MASTERS)  index of the master that timed out, held until the next timeout

Behaviour:
- Reset (RST_I==0 at a clock edge): state IDLE, gnt_o=0, rr pointer=NUM_MASTERS-1 (so master 0 has first priority), outstanding=0, timer=0, block mask=0, timeout_o=0, timeout_id_o=0. Combinationally during reset: all s_* = 0, m_ack_o = 0, m_stall_o = all 1.
- States: IDLE and BUSY.
- IDLE:
  - Eligible requests: req = m_cyc_i & ~block.
  - If req != 0, pick the first set bit searching from ptr+1 upward, with wrap-around.
  - Register gnt_o to that master, set ptr to its index, go to BUSY.
  - Grant latency is 1 cycle: a request sampled at edge N drives s_cyc_o during cycle N+1.
  - All m_stall_o = 1 and all s_* = 0 while IDLE.
- BUSY, with g = granted index:
  - Slave signals: s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & ~full; s_we_o, s_adr_o and s_dat_o come from master g.
  - Returned signals: m_ack_o[g] = s_ack_i; m_stall_o[g] = s_stall_i | full; every other master sees stall=1 and ack=0.
  - full is defined as outstanding == MAX_OUTST.
  - A transfer is accepted when s_stb_o & ~s_stall_i.
  - outstanding += accepted, -= s_ack_i. Accept and ack in the same cycle leave it unchanged.
  - An ack with outstanding==0 is forwarded but does not underflow the counter (clamped at 0).
- Release: m_cyc_i[g]==0 in BUSY gives s_cyc_o=0 that same cycle. At the next edge: state to IDLE, gnt_o=0, outstanding=0, timer=0. Acks arriving after release are not forwarded.
- No back-to-back grant: at least one IDLE cycle always separates grants.
- Timer:
  - In BUSY, timer increments each cycle with outstanding>0 and s_ack_i==0. It clears on any ack, or whenever outstanding==0.
  - When timer==TIMEOUT-1 and the increment condition holds, at that edge: state to IDLE, gnt_o=0, outstanding=0, timer=0.
  - At the same edge: timeout_o=1 for exactly one cycle, timeout_id_o=g, block[g]=1.
- block[k] clears on any cycle where m_cyc_i[k]==0. A timed-out master must drop cyc before it is eligible again.
- A new request during BUSY waits; the grant is never pre-empted except by timeout.
- If RST_I is asserted mid-transfer, the bus is released at that edge with no ack forwarded afterwards.

Test Plan:
1. Reset, then m_cyc_i=3'b001 with 4 pipelined reads at addrs 0x00..0x03 and slave ack 2 cycles after each accept -> gnt_o=001 one cycle after request; 4 acks reach master 0 only; m_dat_o matches slave data; release returns to IDLE.
2. m_cyc_i=3'b111 held, each master doing 1 write per grant -> grant order 0,1,2,0,1,2 with exactly one IDLE cycle between grants; each s_adr_o/s_dat_o matches its owner.
3. Master 1 issues 16 strobes while the slave never stalls and acks nothing until transfer 15 -> after 15 accepts m_stall_o[1]=1 and s_stb_o=0; the first ack drops outstanding to 14 and re-enables one transfer.
4. Slave silent with outstanding=1, TIMEOUT=255 -> forced release 255 cycles after the last ack/accept event; timeout_o pulses once; timeout_id_o=granted index; that master is not re-granted until its m_cyc drops for one cycle.
5. Same-cycle accept and ack across 10 consecutive cycles -> outstanding stays constant; timer stays 0.
6. RST_I driven low while master 2 is BUSY with outstanding=3 -> at that edge gnt_o=0, s_cyc_o=0, all m_stall_o=1; after reset, m_cyc_i=111 grants master 0 first.

Source files
------------

// File: rtl/wb_board_arbiter_if.sv
// Board-memory Wishbone bus bundle shared by the arbiter, its requesters and
// the board-memory slave. The "master" view belongs to the arbiter, which is
// the only master the memory ever sees; the "slave" view is the environment
// side (requesters plus memory) with every direction reversed.
interface wb_board_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
);
  // requester side
  logic [NUM_MASTERS-1:0]        m_cyc_i;
  logic [NUM_MASTERS-1:0]        m_stb_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i;
  logic [DATA_W-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]        m_ack_o;
  logic [NUM_MASTERS-1:0]        m_stall_o;
  // memory side
  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic                          s_we_o;
  logic [ADDR_W-1:0]             s_adr_o;
  logic [DATA_W-1:0]             s_dat_o;
  logic [DATA_W-1:0]             s_dat_i;
  logic                          s_ack_i;
  logic                          s_stall_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_stall_i
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_stall_i
  );
endinterface

// File: rtl/wb_board_arbiter.sv
// Round-robin arbiter for the single board-memory Wishbone slave.
// Grants whole cycle frames (m_cyc), muxes the owner onto the slave, routes
// ack/stall/data back, bounds pipelined outstanding transfers and forcibly
// releases a grant whose slave stops acknowledging.
module wb_board_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MAX_OUTST   = 15,
  parameter int TIMEOUT     = 255
) (
  input  logic                           CLK_I,
  input  logic                           RST_I,
  wb_board_arbiter_if.master             bus,
  output logic [NUM_MASTERS-1:0]         gnt_o,
  output logic                           busy_o,
  output logic                           timeout_o,
  output logic [$clog2(NUM_MASTERS)-1:0] timeout_id_o
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                          state_q, state_d;
  logic [NUM_MASTERS-1:0]          gnt_q, gnt_d;
  logic [IDX_W-1:0]                gidx_q, gidx_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [OUT_W-1:0]                outst_q, outst_d;
  logic [TMR_W-1:0]                timer_q, timer_d;
  logic [NUM_MASTERS-1:0]          block_q, block_d;
  logic                            tout_q, tout_d;
  logic [IDX_W-1:0]                tid_q, tid_d;

  // per-master views of the packed request buses
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] adr_v;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] dat_v;
  assign adr_v = bus.m_adr_i;
  assign dat_v = bus.m_dat_i;

  // act: the bus is really owned this cycle (reset forces everything idle
  // combinationally, even before the first clock edge)
  logic act, full, accept, g_cyc, g_stb, s_stb;
  logic [NUM_MASTERS-1:0] req, ack_v, stall_v;
  logic [IDX_W-1:0]       pick;
  logic                   found;

  assign act  = RST_I && (state_q == BUSY);
  assign full = (outst_q == OUT_W'(MAX_OUTST));

  // mux the granted master onto the slave side
  always_comb begin
    g_cyc = bus.m_cyc_i[gidx_q];
    g_stb = bus.m_stb_i[gidx_q];
    s_stb = act && g_stb && !full;
    bus.s_cyc_o = act && g_cyc;
    bus.s_stb_o = s_stb;
    bus.s_we_o  = act && bus.m_we_i[gidx_q];
    bus.s_adr_o = act ? adr_v[gidx_q] : '0;
    bus.s_dat_o = act ? dat_v[gidx_q] : '0;
  end

  assign accept      = s_stb && !bus.s_stall_i;
  assign bus.m_dat_o = bus.s_dat_i;

  // per-master return path: only the owner sees ack and a real stall
  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_ret
    logic own;
    assign own        = act && (gidx_q == IDX_W'(k));
    assign ack_v[k]   = own && bus.s_ack_i;
    assign stall_v[k] = !own || bus.s_stall_i || full;
  end
  assign bus.m_ack_o   = ack_v;
  assign bus.m_stall_o = stall_v;

  // round-robin pick: first eligible request after the last owner, wrapping
  always_comb begin
    logic [IDX_W:0] cand;
    req   = bus.m_cyc_i & ~block_q;
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) cand = cand - (IDX_W+1)'(NUM_MASTERS);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  // next-state: grant in IDLE; track outstanding/timer, release or time out in BUSY
  always_comb begin
    logic tick, dec;
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    outst_d = outst_q;
    timer_d = timer_q;
    tout_d  = 1'b0;
    tid_d   = tid_q;
    // a master that lets go of cyc becomes eligible again
    block_d = block_q & bus.m_cyc_i;
    tick    = (outst_q != '0) && !bus.s_ack_i;
    dec     = bus.s_ack_i && (outst_q != '0);
    case (state_q)
      IDLE: begin
        outst_d = '0;
        timer_d = '0;
        if (found) begin
          state_d     = BUSY;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          gidx_d      = pick;
          ptr_d       = pick;
        end
      end
      BUSY: begin
        if (tick && (timer_q == TMR_W'(TIMEOUT - 1))) begin
          state_d         = IDLE;
          gnt_d           = '0;
          outst_d         = '0;
          timer_d         = '0;
          tout_d          = 1'b1;
          tid_d           = gidx_q;
          block_d[gidx_q] = 1'b1;
        end else if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          outst_d = '0;
          timer_d = '0;
        end else begin
          // accept and ack in one cycle cancel; a stray ack never underflows
          outst_d = outst_q + OUT_W'(accept) - OUT_W'(dec);
          timer_d = tick ? timer_q + TMR_W'(1) : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset leaves master 0 with first priority
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(NUM_MASTERS - 1);
      outst_q <= '0;
      timer_q <= '0;
      block_q <= '0;
      tout_q  <= 1'b0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      outst_q <= outst_d;
      timer_q <= timer_d;
      block_q <= block_d;
      tout_q  <= tout_d;
      tid_q   <= tid_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign busy_o       = (state_q == BUSY);
  assign timeout_o    = tout_q;
  assign timeout_id_o = tid_q;
endmodule

// File: tb/tb_wb_board_arbiter.sv
// Directed bench for wb_board_arbiter: reset, pipelined reads, round-robin
// fairness, outstanding limit, timeout/blocking, accept+ack balance, mid-grant reset.
module tb_wb_board_arbiter;
  logic       CLK_I = 1'b0;
  logic       RST_I;
  logic [2:0] gnt_o;
  logic       busy_o, timeout_o;
  logic [1:0] timeout_id_o;
  int         n_tests = 0;
  int         n_fail  = 0;

  wb_board_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(8), .DATA_W(8)) bus();

  wb_board_arbiter #(.NUM_MASTERS(3), .ADDR_W(8), .DATA_W(8),
                     .MAX_OUTST(15), .TIMEOUT(255)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .bus(bus),
    .gnt_o(gnt_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .timeout_id_o(timeout_id_o)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic clk1();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic clear_in();
    bus.m_cyc_i   = '0;
    bus.m_stb_i   = '0;
    bus.m_we_i    = '0;
    bus.m_adr_i   = {8'h12, 8'h11, 8'h10};
    bus.m_dat_i   = {8'h52, 8'h51, 8'h50};
    bus.s_dat_i   = '0;
    bus.s_ack_i   = 1'b0;
    bus.s_stall_i = 1'b0;
  endtask

  task automatic do_reset();
    RST_I = 1'b0;
    clear_in();
    clk1();
    clk1();
    RST_I = 1'b1;
  endtask

  task automatic test_reset();
    RST_I = 1'b0;
    clear_in();
    bus.m_cyc_i = 3'b111;
    bus.m_stb_i = 3'b111;
    bus.s_ack_i = 1'b1;
    #1;
    n_tests++; if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_s_cyc: got %b exp 0", bus.s_cyc_o); end
    n_tests++; if (bus.s_stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_s_stb: got %b exp 0", bus.s_stb_o); end
    n_tests++; if (bus.m_stall_o !== 3'b111) begin n_fail++; $display("FAIL rst_stall: got %b exp 111", bus.m_stall_o); end
    n_tests++; if (bus.m_ack_o !== 3'b000) begin n_fail++; $display("FAIL rst_ack: got %b exp 000", bus.m_ack_o); end
    clk1();
    n_tests++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b exp 000", gnt_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    n_tests++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_tout: got %b exp 0", timeout_o); end
    n_tests++; if (timeout_id_o !== 2'd0) begin n_fail++; $display("FAIL rst_tid: got %0d exp 0", timeout_id_o); end
    clear_in();
    clk1();
    RST_I = 1'b1;
  endtask

  // master 0: 4 pipelined reads, slave acks 2 cycles after each transfer
  task automatic test_pipelined_read();
    logic [2:0] exp_ack;
    logic [7:0] exp_dat;
    do_reset();
    for (int t = 0; t <= 8; t++) begin
      if (t > 0) clk1();
      bus.m_cyc_i = (t < 7) ? 3'b001 : 3'b000;
      bus.m_stb_i = (t <= 4) ? 3'b001 : 3'b000;
      bus.m_adr_i = '0;
      bus.m_adr_i[7:0] = 8'((t == 0) ? 0 : t - 1);
      bus.s_ack_i = (t >= 3 && t <= 6);
      bus.s_dat_i = 8'(160 + t - 3);
      #1;
      exp_ack = (t >= 3 && t <= 6) ? 3'b001 : 3'b000;
      exp_dat = 8'(160 + t - 3);
      n_tests++; if (bus.m_ack_o !== exp_ack) begin n_fail++; $display("FAIL rd_ack t%0d: got %b exp %b", t, bus.m_ack_o, exp_ack); end
      if (t == 0) begin
        n_tests++; if (bus.s_cyc_o !== 1'b0 || bus.m_stall_o !== 3'b111) begin n_fail++; $display("FAIL rd_idle: cyc %b stall %b exp 0/111", bus.s_cyc_o, bus.m_stall_o); end
      end
      if (t >= 1 && t <= 4) begin
        n_tests++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL rd_gnt t%0d: got %b exp 001", t, gnt_o); end
        n_tests++; if (bus.s_stb_o !== 1'b1 || bus.s_adr_o !== 8'(t - 1)) begin n_fail++; $display("FAIL rd_req t%0d: stb %b adr %h exp 1/%h", t, bus.s_stb_o, bus.s_adr_o, 8'(t - 1)); end
        n_tests++; if (bus.m_stall_o !== 3'b110) begin n_fail++; $display("FAIL rd_stall t%0d: got %b exp 110", t, bus.m_stall_o); end
      end
      if (t >= 3 && t <= 6) begin
        n_tests++; if (bus.m_dat_o !== exp_dat) begin n_fail++; $display("FAIL rd_dat t%0d: got %h exp %h", t, bus.m_dat_o, exp_dat); end
      end
      if (t == 7) begin
        n_tests++; if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rd_rel_cyc: got %b exp 0", bus.s_cyc_o); end
      end
      if (t == 8) begin
        n_tests++; if (busy_o !== 1'b0 || gnt_o !== 3'b000) begin n_fail++; $display("FAIL rd_rel: busy %b gnt %b exp 0/000", busy_o, gnt_o); end
      end
    end
    clear_in();
  endtask

  // all three request continuously, one write per grant
  task automatic test_round_robin();
    logic [2:0] oh;
    do_reset();
    bus.m_cyc_i = 3'b111;
    bus.m_stb_i = 3'b111;
    bus.m_we_i  = 3'b111;
    #1;
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rr_start_idle: got %b exp 0", busy_o); end
    for (int r = 0; r < 6; r++) begin
      oh = 3'b001 << (r % 3);
      clk1();
      #1;
      n_tests++; if (gnt_o !== oh) begin n_fail++; $display("FAIL rr_gnt r%0d: got %b exp %b", r, gnt_o, oh); end
      n_tests++; if (bus.s_adr_o !== 8'(16 + r % 3) || bus.s_dat_o !== 8'(80 + r % 3) || bus.s_we_o !== 1'b1 || bus.s_stb_o !== 1'b1)
        begin n_fail++; $display("FAIL rr_bus r%0d: adr %h dat %h we %b stb %b exp %h/%h/1/1", r, bus.s_adr_o, bus.s_dat_o, bus.s_we_o, bus.s_stb_o, 8'(16 + r % 3), 8'(80 + r % 3)); end
      clk1();
      bus.m_cyc_i = 3'b111 & ~oh;
      bus.m_stb_i = 3'b111 & ~oh;
      bus.s_ack_i = 1'b1;
      #1;
      n_tests++; if (bus.m_ack_o !== oh || bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rr_ack r%0d: ack %b cyc %b exp %b/0", r, bus.m_ack_o, bus.s_cyc_o, oh); end
      clk1();
      bus.m_cyc_i = 3'b111;
      bus.m_stb_i = 3'b111;
      bus.s_ack_i = 1'b0;
      #1;
      n_tests++; if (busy_o !== 1'b0 || gnt_o !== 3'b000) begin n_fail++; $display("FAIL rr_gap r%0d: busy %b gnt %b exp 0/000", r, busy_o, gnt_o); end
    end
    clear_in();
  endtask

  // master 1 hits the outstanding limit, one ack frees one slot
  task automatic test_outstanding_limit();
    do_reset();
    bus.m_cyc_i = 3'b010;
    bus.m_stb_i = 3'b010;
    for (int k = 1; k <= 15; k++) begin
      clk1();
      #1;
      n_tests++; if (bus.s_stb_o !== 1'b1 || bus.m_stall_o !== 3'b101) begin n_fail++; $display("FAIL lim_acc k%0d: stb %b stall %b exp 1/101", k, bus.s_stb_o, bus.m_stall_o); end
    end
    clk1();
    bus.s_ack_i = 1'b1;
    #1;
    n_tests++; if (bus.s_stb_o !== 1'b0 || bus.m_stall_o !== 3'b111) begin n_fail++; $display("FAIL lim_full: stb %b stall %b exp 0/111", bus.s_stb_o, bus.m_stall_o); end
    n_tests++; if (bus.m_ack_o !== 3'b010) begin n_fail++; $display("FAIL lim_ack: got %b exp 010", bus.m_ack_o); end
    clk1();
    bus.s_ack_i = 1'b0;
    #1;
    n_tests++; if (dut.outst_q !== 4'd14) begin n_fail++; $display("FAIL lim_outst14: got %0d exp 14", dut.outst_q); end
    n_tests++; if (bus.s_stb_o !== 1'b1 || bus.m_stall_o !== 3'b101) begin n_fail++; $display("FAIL lim_reopen: stb %b stall %b exp 1/101", bus.s_stb_o, bus.m_stall_o); end
    clk1();
    #1;
    n_tests++; if (dut.outst_q !== 4'd15 || bus.s_stb_o !== 1'b0) begin n_fail++; $display("FAIL lim_refull: outst %0d stb %b exp 15/0", dut.outst_q, bus.s_stb_o); end
    clear_in();
    clk1();
    clk1();
  endtask

  // master 2 with one transfer outstanding and a silent slave
  task automatic test_timeout();
    int n;
    do_reset();
    bus.m_cyc_i = 3'b100;
    bus.m_stb_i = 3'b100;
    clk1();
    #1;
    n_tests++; if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL to_gnt: got %b exp 100", gnt_o); end
    clk1();
    bus.m_stb_i = 3'b000;
    #1;
    n = 2;
    while (timeout_o !== 1'b1 && n < 600) begin
      clk1();
      n++;
      #1;
    end
    n_tests++; if (n !== 257) begin n_fail++; $display("FAIL to_latency: pulse at cycle %0d exp 257", n); end
    n_tests++; if (busy_o !== 1'b0 || gnt_o !== 3'b000) begin n_fail++; $display("FAIL to_release: busy %b gnt %b exp 0/000", busy_o, gnt_o); end
    n_tests++; if (timeout_id_o !== 2'd2) begin n_fail++; $display("FAIL to_id: got %0d exp 2", timeout_id_o); end
    for (int i = 0; i < 3; i++) begin
      clk1();
      #1;
      n_tests++; if (timeout_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL to_blocked i%0d: tout %b busy %b exp 0/0", i, timeout_o, busy_o); end
    end
    clk1();
    bus.m_cyc_i = 3'b000;
    #1;
    clk1();
    bus.m_cyc_i = 3'b100;
    #1;
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL to_unblock_idle: got %b exp 0", busy_o); end
    clk1();
    #1;
    n_tests++; if (gnt_o !== 3'b100 || timeout_id_o !== 2'd2) begin n_fail++; $display("FAIL to_regrant: gnt %b id %0d exp 100/2", gnt_o, timeout_id_o); end
    clear_in();
    clk1();
    clk1();
  endtask

  // accept and ack together every cycle keep the counter and timer still
  task automatic test_accept_ack_balance();
    do_reset();
    bus.m_cyc_i = 3'b001;
    bus.m_stb_i = 3'b001;
    clk1();
    #1;
    for (int k = 2; k <= 11; k++) begin
      clk1();
      bus.s_ack_i = 1'b1;
      #1;
      n_tests++; if (dut.outst_q !== 4'd1 || dut.timer_q !== 8'd0) begin n_fail++; $display("FAIL bal k%0d: outst %0d timer %0d exp 1/0", k, dut.outst_q, dut.timer_q); end
    end
    clear_in();
    clk1();
    clk1();
  endtask

  // reset while master 2 owns the bus with three transfers in flight
  task automatic test_reset_mid_grant();
    do_reset();
    bus.m_cyc_i = 3'b100;
    bus.m_stb_i = 3'b100;
    clk1(); clk1(); clk1();
    clk1();
    bus.m_stb_i = 3'b000;
    #1;
    n_tests++; if (dut.outst_q !== 4'd3) begin n_fail++; $display("FAIL mr_outst: got %0d exp 3", dut.outst_q); end
    RST_I = 1'b0;
    bus.s_ack_i = 1'b1;
    #1;
    n_tests++; if (bus.s_cyc_o !== 1'b0 || bus.m_stall_o !== 3'b111 || bus.m_ack_o !== 3'b000)
      begin n_fail++; $display("FAIL mr_comb: cyc %b stall %b ack %b exp 0/111/000", bus.s_cyc_o, bus.m_stall_o, bus.m_ack_o); end
    clk1();
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 3'b111;
    bus.m_stb_i = 3'b111;
    #1;
    n_tests++; if (gnt_o !== 3'b000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mr_state: gnt %b busy %b exp 000/0", gnt_o, busy_o); end
    clk1();
    RST_I = 1'b1;
    #1;
    clk1();
    #1;
    n_tests++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL mr_first: got %b exp 001", gnt_o); end
    clear_in();
    clk1();
    clk1();
  endtask

  initial begin
    RST_I = 1'b0;
    clear_in();
    test_reset();
    test_pipelined_read();
    test_round_robin();
    test_outstanding_limit();
    test_timeout();
    test_accept_ack_balance();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
